// File: rtl/write_back_stage_pkg.sv
// Shared processor definitions for the write-back stage: FSM encoding,
// register-file widths and the forwarding history entry layout.
package write_back_stage_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } fwd_entry_t;

    // HI/LO moves win over loads, loads win over ALU results.
    function automatic logic [DATA_W-1:0] wb_select(
        input logic              hilo_to_reg,
        input logic              hi_or_lo,
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] rhi,
        input logic [DATA_W-1:0] rlo,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] alu
    );
        if (hilo_to_reg)     return hi_or_lo ? rhi : rlo;
        else if (mem_to_reg) return rdata;
        else                 return alu;
    endfunction

endpackage

// File: rtl/write_back_stage_fwd_history.sv
// Two-entry forwarding history of the most recent register writes; entry 0 is
// the newest and entry 1 is dropped when it names the same register as entry 0.
module fwd_history
    import write_back_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid0,
    output logic [REG_AW-1:0] o_addr0,
    output logic [DATA_W-1:0] o_data0,
    output logic              o_valid1,
    output logic [REG_AW-1:0] o_addr1,
    output logic [DATA_W-1:0] o_data1
);

    fwd_entry_t r_e0, r_e1;
    fwd_entry_t w_e0_next, w_e1_next;

    always_comb begin
        w_e0_next       = '{valid: 1'b1, addr: i_addr, data: i_data};
        w_e1_next       = r_e0;
        w_e1_next.valid = r_e0.valid && (r_e0.addr != i_addr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0 <= '0;
            r_e1 <= '0;
        end else if (i_push) begin
            r_e0 <= w_e0_next;
            r_e1 <= w_e1_next;
        end
    end

    assign o_valid0 = r_e0.valid;
    assign o_addr0  = r_e0.addr;
    assign o_data0  = r_e0.data;
    assign o_valid1 = r_e1.valid;
    assign o_addr1  = r_e1.addr;
    assign o_data1  = r_e1.data;

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB write-back: selects write data, qualifies the register write, stalls
// the pipe while a load waits for memory and keeps a small forwarding history.
module write_back_stage
    import write_back_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ValidIn,
    input  logic              RegWriteIn,
    input  logic              MoveNotZeroIn,
    input  logic              DontMoveIn,
    input  logic              HiOrLoIn,
    input  logic              MemToRegIn,
    input  logic              HiLoToRegIn,
    input  logic [DATA_W-1:0] RHiIn,
    input  logic [DATA_W-1:0] RLoIn,
    input  logic [DATA_W-1:0] ZeroIn,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [DATA_W-1:0] ReadDataIn,
    input  logic [REG_AW-1:0] WriteAddressIn,
    input  logic              ReadDataValid,
    input  logic              Flush,
    output logic              StallOut,
    output logic              RegWriteOut,
    output logic [REG_AW-1:0] WriteAddressOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic              FwdValid0,
    output logic              FwdValid1,
    output logic [REG_AW-1:0] FwdAddr0,
    output logic [REG_AW-1:0] FwdAddr1,
    output logic [DATA_W-1:0] FwdData0,
    output logic [DATA_W-1:0] FwdData1,
    output logic [DATA_W-1:0] RetiredCount
);

    wb_state_e         r_state, w_next_state;
    logic              w_stall, w_complete, w_commit_en, w_commit;
    logic [DATA_W-1:0] w_wdata;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_retired;

    assign w_wdata = wb_select(HiLoToRegIn, HiOrLoIn, MemToRegIn,
                               RHiIn, RLoIn, ReadDataIn, ALUResultIn);

    // Conditional moves gate the write on ZeroIn; $0 is never written.
    always_comb begin
        w_commit_en = RegWriteIn;
        if (DontMoveIn)
            w_commit_en = RegWriteIn && (MoveNotZeroIn ? (ZeroIn != '0) : (ZeroIn == '0));
        if (WriteAddressIn == '0)
            w_commit_en = 1'b0;
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        if (Flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ValidIn) begin
                        if (MemToRegIn && !HiLoToRegIn && !ReadDataValid) begin
                            w_next_state = WAIT_MEM;
                            w_stall      = 1'b1;
                        end else begin
                            w_complete = 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    // MEM_WB is held by the stall, so its inputs still describe the load.
                    if (ReadDataValid) begin
                        w_complete   = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    assign w_commit = w_complete && w_commit_en;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_reg_write <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_retired   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_reg_write <= w_commit;
            if (w_commit) begin
                r_waddr   <= WriteAddressIn;
                r_wdata   <= w_wdata;
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    fwd_history u_fwd_history (
        .i_clk    (Clk),
        .i_rst_n  (Rst_n),
        .i_push   (w_commit),
        .i_addr   (WriteAddressIn),
        .i_data   (w_wdata),
        .o_valid0 (FwdValid0),
        .o_addr0  (FwdAddr0),
        .o_data0  (FwdData0),
        .o_valid1 (FwdValid1),
        .o_addr1  (FwdAddr1),
        .o_data1  (FwdData1)
    );

    // Reset must drop the stall even while the MEM_WB inputs still look like a pending load.
    assign StallOut        = w_stall && Rst_n;
    assign RegWriteOut     = r_reg_write;
    assign WriteAddressOut = r_waddr;
    assign WriteDataOut    = r_wdata;
    assign RetiredCount    = r_retired;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: hand-computed vectors checked with
// immediate assertions one step at a time.
module tb_write_back_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ValidIn, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn;
    logic [31:0] RHiIn, RLoIn, ZeroIn, ALUResultIn, ReadDataIn;
    logic [4:0]  WriteAddressIn;
    logic        ReadDataValid, Flush;
    logic        StallOut, RegWriteOut;
    logic [4:0]  WriteAddressOut;
    logic [31:0] WriteDataOut;
    logic        FwdValid0, FwdValid1;
    logic [4:0]  FwdAddr0, FwdAddr1;
    logic [31:0] FwdData0, FwdData1;
    logic [31:0] RetiredCount;

    int errors = 0;
    int checks = 0;

    write_back_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .ValidIn(ValidIn), .RegWriteIn(RegWriteIn),
        .MoveNotZeroIn(MoveNotZeroIn), .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn),
        .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn), .RHiIn(RHiIn), .RLoIn(RLoIn),
        .ZeroIn(ZeroIn), .ALUResultIn(ALUResultIn), .ReadDataIn(ReadDataIn),
        .WriteAddressIn(WriteAddressIn), .ReadDataValid(ReadDataValid), .Flush(Flush),
        .StallOut(StallOut), .RegWriteOut(RegWriteOut), .WriteAddressOut(WriteAddressOut),
        .WriteDataOut(WriteDataOut), .FwdValid0(FwdValid0), .FwdValid1(FwdValid1),
        .FwdAddr0(FwdAddr0), .FwdAddr1(FwdAddr1), .FwdData0(FwdData0), .FwdData1(FwdData1),
        .RetiredCount(RetiredCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ValidIn = 0; RegWriteIn = 0; MoveNotZeroIn = 0; DontMoveIn = 0; HiOrLoIn = 0;
        MemToRegIn = 0; HiLoToRegIn = 0; RHiIn = 0; RLoIn = 0; ZeroIn = 0;
        ALUResultIn = 0; ReadDataIn = 0; WriteAddressIn = 0; ReadDataValid = 0; Flush = 0;
    endtask

    task automatic alu_write(input logic [4:0] a, input logic [31:0] d);
        ValidIn = 1; RegWriteIn = 1; MemToRegIn = 0; HiLoToRegIn = 0; DontMoveIn = 0;
        WriteAddressIn = a; ALUResultIn = d;
    endtask

    initial begin
        clear_inputs();
        Rst_n = 0;
        #12;
        chk("rst_regwrite", RegWriteOut, 0);
        chk("rst_waddr", WriteAddressOut, 0);
        chk("rst_wdata", WriteDataOut, 0);
        chk("rst_stall", StallOut, 0);
        chk("rst_fwd", {FwdValid0, FwdValid1, FwdAddr0, FwdAddr1}, 0);
        chk("rst_retired", RetiredCount, 0);
        Rst_n = 1;

        // ALU write on the first edge after reset release
        alu_write(5, 32'h12345678);
        tick();
        chk("alu_regwrite", RegWriteOut, 1);
        chk("alu_waddr", WriteAddressOut, 5);
        chk("alu_wdata", WriteDataOut, 32'h12345678);
        chk("alu_fwd0", {FwdValid0, FwdAddr0}, {1'b1, 5'd5});
        chk("alu_retired", RetiredCount, 1);

        // Conditional moves
        alu_write(6, 32'h11); DontMoveIn = 1; MoveNotZeroIn = 1; ZeroIn = 0;
        tick();
        chk("movn_zero_regwrite", RegWriteOut, 0);
        chk("movn_zero_waddr_hold", WriteAddressOut, 5);
        chk("movn_zero_retired", RetiredCount, 1);
        ZeroIn = 7; ALUResultIn = 32'h22;
        tick();
        chk("movn_nz_regwrite", RegWriteOut, 1);
        chk("movn_nz_wdata", {WriteAddressOut, WriteDataOut}, {5'd6, 32'h22});
        MoveNotZeroIn = 0; ZeroIn = 0; ALUResultIn = 32'h33; WriteAddressIn = 7;
        tick();
        chk("movz_regwrite", RegWriteOut, 1);
        chk("movz_wdata", {WriteAddressOut, WriteDataOut}, {5'd7, 32'h33});
        chk("movz_retired", RetiredCount, 3);
        DontMoveIn = 0; ValidIn = 0; WriteAddressIn = 9;
        tick();
        chk("invalid_regwrite", RegWriteOut, 0);
        chk("invalid_stall", StallOut, 0);
        chk("invalid_retired", RetiredCount, 3);

        // Load waits three cycles for memory
        ValidIn = 1; RegWriteIn = 1; MemToRegIn = 1; ReadDataValid = 0; WriteAddressIn = 8;
        #1 chk("load_stall_c1", StallOut, 1);
        tick();
        chk("load_stall_c2", StallOut, 1);
        chk("load_wait_regwrite", RegWriteOut, 0);
        tick();
        chk("load_stall_c3", StallOut, 1);
        tick();
        ReadDataValid = 1; ReadDataIn = 32'hFFFFFFFF;
        #1 chk("load_data_stall", StallOut, 0);
        tick();
        chk("load_regwrite", RegWriteOut, 1);
        chk("load_wdata", {WriteAddressOut, WriteDataOut}, {5'd8, 32'hFFFFFFFF});
        chk("load_retired", RetiredCount, 4);
        chk("load_fwd1", {FwdValid1, FwdAddr1, FwdData1}, {1'b1, 5'd7, 32'h33});
        MemToRegIn = 0; ReadDataValid = 0;

        // HI/LO select; HI/LO beats a pending-load indication; $0 is never written
        HiLoToRegIn = 1; HiOrLoIn = 1; RHiIn = 32'hAAAA0000; RLoIn = 32'h0000BBBB; WriteAddressIn = 9;
        tick();
        chk("hi_wdata", WriteDataOut, 32'hAAAA0000);
        HiOrLoIn = 0; MemToRegIn = 1; WriteAddressIn = 10;
        #1 chk("lo_no_stall", StallOut, 0);
        tick();
        chk("lo_wdata", {RegWriteOut, WriteDataOut}, {1'b1, 32'h0000BBBB});
        chk("lo_retired", RetiredCount, 6);
        MemToRegIn = 0; WriteAddressIn = 0;
        tick();
        chk("r0_regwrite", RegWriteOut, 0);
        chk("r0_retired", RetiredCount, 6);
        chk("r0_wdata_hold", WriteDataOut, 32'h0000BBBB);
        HiLoToRegIn = 0;

        // Flush with ReadDataValid in WAIT_MEM
        MemToRegIn = 1; WriteAddressIn = 11; ReadDataValid = 0;
        tick();
        chk("flush_pre_stall", StallOut, 1);
        ReadDataValid = 1; ReadDataIn = 32'h55; Flush = 1;
        #1 chk("flush_stall", StallOut, 0);
        tick();
        chk("flush_regwrite", RegWriteOut, 0);
        chk("flush_retired", RetiredCount, 6);
        chk("flush_waddr_hold", WriteAddressOut, 10);
        Flush = 0; ReadDataValid = 0; ValidIn = 0;
        tick();
        chk("flush_idle_stall", StallOut, 0);

        // Flush of a valid ALU write in IDLE keeps history and count
        alu_write(12, 32'h77); Flush = 1;
        tick();
        chk("flush_idle_regwrite", RegWriteOut, 0);
        chk("flush_fwd_kept", {FwdValid0, FwdAddr0, FwdData0, FwdValid1, FwdAddr1},
            {1'b1, 5'd10, 32'h0000BBBB, 1'b1, 5'd9});
        chk("flush_idle_retired", RetiredCount, 6);
        Flush = 0;

        // Asynchronous reset mid-WAIT_MEM
        MemToRegIn = 1; WriteAddressIn = 13; ReadDataValid = 0;
        tick();
        chk("rst2_pre_stall", StallOut, 1);
        Rst_n = 0;
        #1;
        chk("rst2_stall", StallOut, 0);
        chk("rst2_outs", {RegWriteOut, WriteAddressOut, WriteDataOut}, 0);
        chk("rst2_fwd", {FwdValid0, FwdValid1, FwdAddr0, FwdAddr1}, 0);
        chk("rst2_fwd_data", FwdData0 | FwdData1, 0);
        chk("rst2_retired", RetiredCount, 0);
        clear_inputs();
        #1 Rst_n = 1;

        // History: r3, r4, r3, r4, then r4 again
        alu_write(3, 32'h300);
        tick();
        chk("hist_first_commit", {RegWriteOut, RetiredCount}, {1'b1, 32'd1});
        alu_write(4, 32'h400);
        tick();
        alu_write(3, 32'h301);
        tick();
        chk("hist_e0", {FwdValid0, FwdAddr0, FwdData0}, {1'b1, 5'd3, 32'h301});
        chk("hist_e1", {FwdValid1, FwdAddr1, FwdData1}, {1'b1, 5'd4, 32'h400});
        alu_write(4, 32'h401);
        tick();
        chk("hist2_e0", {FwdValid0, FwdAddr0, FwdData0}, {1'b1, 5'd4, 32'h401});
        chk("hist2_e1", {FwdValid1, FwdAddr1, FwdData1}, {1'b1, 5'd3, 32'h301});
        alu_write(4, 32'h402);
        tick();
        chk("hist_dup_e0", {FwdValid0, FwdAddr0, FwdData0}, {1'b1, 5'd4, 32'h402});
        chk("hist_dup_e1", {FwdValid1, FwdAddr1, FwdData1}, {1'b0, 5'd4, 32'h401});
        chk("hist_retired", RetiredCount, 5);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Rst_n  in  1  asynchronous active-low reset.
REQ-004 ValidIn  in  1  MEM_WB holds a live instruction this cycle.
REQ-005 RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn  in  1 each  MEM_WB control outputs.
REQ-006 RHiIn, RLoIn, ZeroIn, ALUResultIn, ReadDataIn  in  32 each  MEM_WB data outputs.
REQ-007 WriteAddressIn  in  5  destination register.
REQ-008 ReadDataValid  in  1  data memory read data is present on ReadDataIn.
REQ-009 Flush  in  1  discard the current and pending instruction.
REQ-010 StallOut  out  1  hold MEM_WB and earlier stages.
REQ-011 RegWriteOut  out  1  register file write enable.
REQ-012 WriteAddressOut  out  5  register file write address.
REQ-013 WriteDataOut  out  32  register file write data.
REQ-014 FwdValid0/1  out  1 each  forwarding history entries valid; entry 0 is the newest.
REQ-015 FwdAddr0/1  out  5 each; FwdData0/1  out  32 each  forwarding history contents.
REQ-016 RetiredCount  out  32  count of committed register writes.

Function
REQ-017 Select: HiLoToRegIn=1 -> (HiOrLoIn ? RHiIn : RLoIn); else MemToRegIn=1 -> ReadDataIn; else ALUResultIn.
REQ-018 Commit enable:
  - DontMoveIn=0 -> commit = RegWriteIn.
  - DontMoveIn=1 -> commit = RegWriteIn & (MoveNotZeroIn ? ZeroIn!=0 : ZeroIn==0).
  - WriteAddressIn=0 -> commit forced to 0.
REQ-019 FSM states: IDLE, WAIT_MEM.
REQ-020 IDLE, ValidIn & MemToRegIn & ~HiLoToRegIn & ~ReadDataValid -> WAIT_MEM; StallOut=1 combinationally in that same cycle.
REQ-021 WAIT_MEM: StallOut=1 until ReadDataValid=1; on that cycle StallOut=0, the instruction completes, and the next state is IDLE.
REQ-022 Completion in IDLE, or from WAIT_MEM on the ReadDataValid cycle, with commit=1: on the next rising edge register RegWriteOut=1, WriteAddressOut, and WriteDataOut, giving 1-cycle latency.
REQ-023 Any cycle with no completing commit: RegWriteOut=0 on the next edge; WriteAddressOut and WriteDataOut hold their values.
REQ-024 On each completing commit, shift entry 0 into entry 1 and load entry 0 with the new address and data, both valid.
REQ-025 If the new address equals FwdAddr1, clear FwdValid1 after the shift so there are no stale duplicates.
REQ-026 RetiredCount increments by 1 per completing commit and wraps from 0xFFFFFFFF to 0.
REQ-027 Flush, which has priority over all other events:
  - next state = IDLE, StallOut=0.
  - no commit on that edge.
  - forwarding history and RetiredCount are kept.
REQ-028 If Flush and ReadDataValid occur in the same WAIT_MEM cycle, Flush wins and nothing is written.
REQ-029 ValidIn=0 SHALL produce no commit and no state change from IDLE.

Reset
REQ-030 Asserting Rst_n low, at any time and including mid-WAIT_MEM, SHALL asynchronously force:
  - state = IDLE, StallOut=0, RegWriteOut=0.
  - WriteAddressOut=0, WriteDataOut=0.
  - FwdValid0/1=0, FwdAddr0/1=0, FwdData0/1=0.
  - RetiredCount=0.
REQ-031 The first commit is possible on the first rising edge after Rst_n deasserts.

Structure
REQ-032 Put the FSM state encoding (IDLE=0, WAIT_MEM=1), register address width 5, and data width 32 in the shared processor package.
REQ-033 The two-entry forwarding history SHALL be one sub-module, fwd_history, with shift, invalidate, and reset behaviour.
REQ-034 Write-data selection and commit-enable logic are combinational; all outputs except StallOut are registered.

Verification
REQ-035 ALU write: ValidIn=1, RegWriteIn=1, ALUResultIn=0x12345678, WriteAddressIn=5 -> next edge: RegWriteOut=1, WriteAddressOut=5, WriteDataOut=0x12345678, FwdAddr0=5, RetiredCount=1.
REQ-036 Conditional moves: DontMoveIn=1, MoveNotZeroIn=1, ZeroIn=0 -> RegWriteOut=0. Then ZeroIn=7 -> RegWriteOut=1. Then MoveNotZeroIn=0, ZeroIn=0 -> RegWriteOut=1.
REQ-037 Load wait: MemToRegIn=1, ReadDataValid=0 for 3 cycles, then 1 with ReadDataIn=0xFFFFFFFF -> StallOut=1 for 3 cycles, then RegWriteOut=1 with WriteDataOut=0xFFFFFFFF.
REQ-038 HI/LO select and $0: HiLoToRegIn=1, HiOrLoIn=1, RHiIn=0xAAAA0000 -> WriteDataOut=0xAAAA0000. With HiOrLoIn=0 -> WriteDataOut=RLoIn. WriteAddressIn=0 -> RegWriteOut=0 and RetiredCount unchanged.
REQ-039 Flush and reset in WAIT_MEM: Flush together with ReadDataValid -> no write, state IDLE. A separate Rst_n pulse in WAIT_MEM -> all outputs 0 immediately, without waiting for a clock edge.
REQ-040 History: commits to r3, r4, r3 -> FwdAddr0=3, FwdAddr1=4, both valid. A following commit to r4 -> FwdAddr0=4, FwdAddr1=3, with FwdData matching each write.
